// File: rtl/gcd_pkg.sv
// Shared state encoding and mux/bus select constants for the GCD sequencer.
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  localparam logic BUS_DATA = 1'b1;
  localparam logic BUS_SUB  = 1'b0;

  function automatic logic flags_onehot(input logic lt, input logic gt, input logic eq);
    return ({lt, gt, eq} == 3'b100) || ({lt, gt, eq} == 3'b010) || ({lt, gt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtract-step counter: synchronous clear, increment, saturates at MAX_ITER.
// at_max_o tells the sequencer the step budget is exhausted.
module gcd_iter_cnt #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              at_max_o
);

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == LIMIT);
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_seq_ctrl.sv
// Sequencer for the subtractive GCD datapath: loads A then B, then steers
// subtract steps from the comparator flags until eq, timeout or illegal flags.
module gcd_seq_ctrl
  import gcd_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     a_in,
  input  logic [DW-1:0]     b_in,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic [DW-1:0]     data_out,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_e        state_q, state_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          cnt_clr, cnt_inc, cnt_at_max;

  gcd_iter_cnt #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .cnt_o    (iter_cnt),
    .at_max_o (cnt_at_max)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    data_out = '0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = SEL_A;
    sel2     = SEL_A;
    sel_in   = BUS_SUB;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a_in;
          opb_d   = b_in;
          cnt_clr = 1'b1;
          state_d = ((a_in == '0) || (b_in == '0)) ? S_ERR : S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        busy     = 1'b1;
        data_out = opa_q;
        sel_in   = BUS_DATA;
        ldA      = 1'b1;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        busy     = 1'b1;
        data_out = opb_q;
        sel_in   = BUS_DATA;
        ldB      = 1'b1;
        state_d  = S_COMPARE;
      end
      S_COMPARE: begin
        busy = 1'b1;
        // eq wins over the step budget: a job finishing on its last allowed step is still good
        if (!flags_onehot(lt, gt, eq)) begin
          state_d = S_ERR;
        end else if (eq) begin
          state_d = S_DONE;
        end else if (cnt_at_max) begin
          state_d = S_ERR;
        end else if (lt) begin
          sel1    = SEL_B;
          sel2    = SEL_A;
          ldB     = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          sel1    = SEL_A;
          sel2    = SEL_B;
          ldA     = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Sequencer plus a behavioural subtractive datapath, checked against a Euclid reference.
module tb_gcd_seq_ctrl;

  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start_r = '0;
  logic [15:0] ain_r [2];
  logic [15:0] bin_r [2];
  logic [15:0] dout_w [2];
  logic [15:0] aout_w [2];
  logic [15:0] iter_w [2];
  logic [1:0]  ldA_w, ldB_w, sel1_w, sel2_w, selin_w, busy_w, done_w, err_w;
  logic [1:0]  lt_w, gt_w, eq_w;

  int n_vec = 0;
  int n_bad = 0;
  int excl_bad = 0;

  always #5 clk = ~clk;

  gcd_seq_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .a_in(ain_r[0]), .b_in(bin_r[0]),
    .lt(lt_w[0]), .gt(gt_w[0]), .eq(eq_w[0]), .data_out(dout_w[0]),
    .ldA(ldA_w[0]), .ldB(ldB_w[0]), .sel1(sel1_w[0]), .sel2(sel2_w[0]), .sel_in(selin_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .iter_cnt(iter_w[0])
  );

  gcd_seq_ctrl #(.MAX_ITER(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .a_in(ain_r[1]), .b_in(bin_r[1]),
    .lt(lt_w[1]), .gt(gt_w[1]), .eq(eq_w[1]), .data_out(dout_w[1]),
    .ldA(ldA_w[1]), .ldB(ldB_w[1]), .sel1(sel1_w[1]), .sel2(sel2_w[1]), .sel_in(selin_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .iter_cnt(iter_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic [15:0] ra, rb, sub, bus;
    assign sub       = (sel1_w[g] ? rb : ra) - (sel2_w[g] ? rb : ra);
    assign bus       = selin_w[g] ? dout_w[g] : sub;
    assign lt_w[g]   = ra < rb;
    assign gt_w[g]   = ra > rb;
    assign eq_w[g]   = ra == rb;
    assign aout_w[g] = ra;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        ra <= '0;
        rb <= '0;
      end else begin
        if (ldA_w[g]) ra <= bus;
        if (ldB_w[g]) rb <= bus;
      end
    end
  end

  always @(negedge clk) begin
    if ((ldA_w & ldB_w) != 2'b00) excl_bad++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Euclid by division; each quotient counts as that many subtractions, except the
  // last one, where the pair becomes equal one subtraction early.
  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    int x = a;
    int y = b;
    n = 0;
    while (y != 0) begin
      int q = x / y;
      int r = x % y;
      n += (r == 0) ? q - 1 : q;
      x = y;
      y = r;
    end
    g = x;
  endfunction

  // Cycle index c = 0 is sampled just after the edge that accepts start.
  task automatic run_job(input int idx, input int a, input int b,
                         output int t_done, output int t_err,
                         output bit saw_ld, output bit saw_busy);
    @(negedge clk);
    ain_r[idx]   = 16'(a);
    bin_r[idx]   = 16'(b);
    start_r[idx] = 1'b1;
    @(posedge clk); #1;
    start_r[idx] = 1'b0;
    t_done = -1; t_err = -1; saw_ld = 0; saw_busy = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (ldA_w[idx] | ldB_w[idx]) saw_ld = 1;
      if (busy_w[idx]) saw_busy = 1;
      if (done_w[idx]) begin t_done = c; break; end
      if (err_w[idx])  begin t_err = c;  break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic job_ok(input string tag, input int a, input int b);
    int g, n, td, te;
    bit sl, sb;
    ref_gcd(a, b, g, n);
    run_job(0, a, b, td, te, sl, sb);
    check({tag, "_lat"},  td, 3 + n);
    check({tag, "_err"},  te, -1);
    check({tag, "_aout"}, int'(aout_w[0]), g);
    check({tag, "_iter"}, int'(iter_w[0]), n);
  endtask

  task automatic job_zero(input string tag, input int a, input int b);
    int td, te;
    bit sl, sb;
    run_job(0, a, b, td, te, sl, sb);
    check({tag, "_errlat"}, te, 0);
    check({tag, "_done"},   td, -1);
    check({tag, "_ld"},     int'(sl), 0);
    check({tag, "_busy"},   int'(sb), 0);
    check({tag, "_iter"},   int'(iter_w[0]), 0);
  endtask

  initial begin
    int td, te, a, b;
    bit sl, sb;
    int la [$];
    int dn [$];

    for (int i = 0; i < 2; i++) begin
      ain_r[i] = '0;
      bin_r[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_dout", int'(dout_w[i]), 0);
      check("rst_ctl", int'({ldA_w[i], ldB_w[i], sel1_w[i], sel2_w[i], selin_w[i],
                             busy_w[i], done_w[i], err_w[i]}), 0);
      check("rst_iter", int'(iter_w[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    job_ok("p143_78", 143, 78);
    job_ok("p12_12", 12, 12);
    job_zero("z0_5", 0, 5);
    job_zero("z5_0", 5, 0);

    // tight step budget on the second instance
    run_job(1, 143, 78, td, te, sl, sb);
    check("max_errlat", te, 7);
    check("max_done", td, -1);
    check("max_iter", int'(iter_w[1]), 4);

    for (int j = 0; j < 24; j++) begin
      a = $urandom_range(1, 300);
      b = $urandom_range(1, 300);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) a = 0; else b = 0;
      end
      if (a == 0 || b == 0) job_zero("rnd_z", a, b);
      else job_ok("rnd", a, b);
    end

    // reset in the middle of a long job
    @(negedge clk);
    ain_r[0] = 16'hFFFF;
    bin_r[0] = 16'd1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("mid_busy", int'(busy_w[0]), 1);
    rst = 1'b1;
    #1;
    check("arst_dout", int'(dout_w[0]), 0);
    check("arst_ctl", int'({ldA_w[0], ldB_w[0], sel1_w[0], sel2_w[0], selin_w[0],
                            busy_w[0], done_w[0], err_w[0]}), 0);
    check("arst_iter", int'(iter_w[0]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    job_ok("post_rst", 21, 14);

    // start held high: next job only after DONE returns to IDLE
    @(negedge clk);
    ain_r[0] = 16'd21;
    bin_r[0] = 16'd14;
    start_r[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (ldA_w[0] && selin_w[0]) la.push_back(c);
      if (done_w[0]) dn.push_back(c);
    end
    @(negedge clk);
    start_r[0] = 1'b0;
    check("hold_nload", la.size(), 2);
    check("hold_ndone", dn.size(), 2);
    if (la.size() == 2 && dn.size() == 2) begin
      check("hold_load0", la[0], 0);
      check("hold_done0", dn[0], 5);
      check("hold_load1", la[1], 7);
      check("hold_done1", dn[1], 12);
    end
    check("hold_aout", int'(aout_w[0]), 7);
    repeat (3) @(posedge clk);
    #1;
    check("hold_idle", int'(busy_w[0]), 0);

    check("ld_excl", excl_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
